// File: rtl/gpio_fifo_top_serial.sv
// GPIO serial port: write-side FIFO feeding a serial transmitter, plus a serial receiver.
// Define GPIO_LSB_FIRST_EN to put words on the wire LSB-first (default is MSB-first).
module gpio_fifo_top_serial #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             gpio_direction,
    input  logic             gpio_in,
    output logic             serial_out,
    output logic [DSIZE-1:0] pin_status,
    output logic             wfull
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int CW    = (DSIZE > 1) ? $clog2(DSIZE) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } tx_state_t;

    tx_state_t        state;
    logic [DSIZE-1:0] mem [0:DEPTH-1];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic [DSIZE-1:0] head;
    logic [DSIZE-1:0] tx_sr;
    logic [DSIZE-1:0] rx_sr;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    rx_cnt;
    logic             empty;
    logic             push;
    logic             pop;
    logic             rx_active;
    logic             tx_first;
    logic [DSIZE-1:0] tx_load;
    logic             tx_bit;
    logic [DSIZE-1:0] tx_shifted;
    logic [DSIZE-1:0] rx_next;

    assign empty = (wptr == rptr);
    assign wfull = (wptr[ASIZE] != rptr[ASIZE]) &&
                   (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
    assign push  = winc && !wfull;
    assign head  = mem[rptr[ASIZE-1:0]];

    // A pop happens from IDLE or on the last bit of a frame, giving gap-free back-to-back frames.
    assign pop = gpio_direction && !empty &&
                 ((state == IDLE) || ((state == SHIFT) && (bit_cnt == '0)));

    assign rx_active = !gpio_direction && (state == IDLE);

`ifdef GPIO_LSB_FIRST_EN
    assign tx_first   = head[0];
    assign tx_load    = head >> 1;
    assign tx_bit     = tx_sr[0];
    assign tx_shifted = tx_sr >> 1;
    assign rx_next    = {gpio_in, rx_sr[DSIZE-1:1]};
`else
    assign tx_first   = head[DSIZE-1];
    assign tx_load    = head << 1;
    assign tx_bit     = tx_sr[DSIZE-1];
    assign tx_shifted = tx_sr << 1;
    assign rx_next    = {rx_sr[DSIZE-2:0], gpio_in};
`endif

    always_ff @(posedge wclk) begin
        if (push) begin
            mem[wptr[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            state      <= IDLE;
            serial_out <= 1'b0;
            pin_status <= '0;
            tx_sr      <= '0;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            rx_cnt     <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end

            if (pop) begin
                rptr       <= rptr + 1'b1;
                pin_status <= head;
                serial_out <= tx_first;
                tx_sr      <= tx_load;
                bit_cnt    <= CW'(DSIZE - 1);
                state      <= SHIFT;
            end else if ((state == SHIFT) && (bit_cnt != '0)) begin
                serial_out <= tx_bit;
                tx_sr      <= tx_shifted;
                bit_cnt    <= bit_cnt - 1'b1;
            end else begin
                serial_out <= 1'b0;
                state      <= IDLE;
            end

            // Receiver never overlaps a pop, so its pin_status update cannot collide with TX.
            if (rx_active) begin
                rx_sr <= rx_next;
                if (rx_cnt == CW'(DSIZE - 1)) begin
                    pin_status <= rx_next;
                    rx_cnt     <= '0;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end else begin
                rx_sr  <= '0;
                rx_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gpio_fifo_top_serial.sv
// Directed self-checking bench for gpio_fifo_top_serial (default MSB-first build).
module tb_gpio_fifo_top_serial;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [7:0] wdata;
    logic       gpio_direction;
    logic       gpio_in;
    logic       serial_out;
    logic [7:0] pin_status;
    logic       wfull;

    int check_count;
    int error_count;

    gpio_fifo_top_serial #(.DSIZE(8), .ASIZE(4)) dut (
        .wclk           (wclk),
        .wrst_n         (wrst_n),
        .winc           (winc),
        .wdata          (wdata),
        .gpio_direction (gpio_direction),
        .gpio_in        (gpio_in),
        .serial_out     (serial_out),
        .pin_status     (pin_status),
        .wfull          (wfull)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Drive one cycle of inputs, let the rising edge happen, then settle before sampling.
    task automatic applyStimulus(input logic inc, input logic [7:0] data,
                                 input logic dir, input logic gin);
        winc           = inc;
        wdata          = data;
        gpio_direction = dir;
        gpio_in        = gin;
        @(posedge wclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [15:0] b2b;
        logic [7:0]  word;
        logic [7:0]  rx_a;
        logic [7:0]  rx_b;
        logic [7:0]  rx_c;
        logic [7:0]  sw_word;

        check_count = 0;
        error_count = 0;
        b2b     = 16'h3CFF;
        rx_a    = 8'hCA;
        rx_b    = 8'h55;
        rx_c    = 8'h96;
        sw_word = 8'h81;

        // Reset held for three edges while a write is attempted
        wrst_n = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("reset_serial_out", 32'(serial_out), 32'h0);
        checkOutput("reset_pin_status", 32'(pin_status), 32'h00);
        checkOutput("reset_wfull", 32'(wfull), 32'h0);
        wrst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post_reset_serial_out", 32'(serial_out), 32'h0);
        checkOutput("post_reset_pin_status", 32'(pin_status), 32'h00);

        // Single frame 0xA5
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        checkOutput("tx_a5_before_first_bit", 32'(serial_out), 32'h0);
        word = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput($sformatf("tx_a5_bit%0d", i), 32'(serial_out), 32'(word[7-i]));
            if (i == 0) checkOutput("tx_a5_pin_status", 32'(pin_status), 32'hA5);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("tx_a5_idle_after", 32'(serial_out), 32'h0);

        // Back-to-back frames 0x3C, 0xFF
        applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
        checkOutput("b2b_bit0", 32'(serial_out), 32'(b2b[15]));
        checkOutput("b2b_pin_3c", 32'(pin_status), 32'h3C);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput($sformatf("b2b_bit%0d", i), 32'(serial_out), 32'(b2b[15-i]));
            if (i == 8) checkOutput("b2b_pin_ff", 32'(pin_status), 32'hFF);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("b2b_idle_after", 32'(serial_out), 32'h0);

        // Fill the FIFO in receive mode; the 17th write must be dropped
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 14) checkOutput("fill_not_full_15", 32'(wfull), 32'h0);
            if (i == 15) checkOutput("fill_full_16", 32'(wfull), 32'h1);
            if (i == 16) checkOutput("fill_full_17", 32'(wfull), 32'h1);
        end
        for (int t = 0; t < 128; t++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            word = 8'(t / 8);
            if (t == 0) checkOutput("drain_wfull_drop", 32'(wfull), 32'h0);
            if ((t % 8) == 0)
                checkOutput($sformatf("drain_pin_w%0d", t / 8), 32'(pin_status), 32'(word));
            checkOutput($sformatf("drain_bit%0d", t), 32'(serial_out), 32'(word[7 - (t % 8)]));
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("drain_idle_after", 32'(serial_out), 32'h0);
        checkOutput("drain_last_word", 32'(pin_status), 32'h0F);
        checkOutput("drain_wfull_end", 32'(wfull), 32'h0);

        // Receive 0xCA, then hold it until a further full word arrives (0x55)
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, rx_a[7-i]);
            if (i == 6) checkOutput("rx_ca_partial", 32'(pin_status), 32'h0F);
        end
        checkOutput("rx_ca_word", 32'(pin_status), 32'hCA);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, rx_b[7-i]);
            if (i == 6) checkOutput("rx_ca_hold", 32'(pin_status), 32'hCA);
        end
        checkOutput("rx_55_word", 32'(pin_status), 32'h55);

        // Frame 0x81 with direction cleared after three bits
        applyStimulus(1'b1, 8'h81, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, (i < 3) ? 1'b1 : 1'b0, 1'b1);
            checkOutput($sformatf("switch_bit%0d", i), 32'(serial_out), 32'(sw_word[7-i]));
            if (i == 0) checkOutput("switch_pin_81", 32'(pin_status), 32'h81);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("switch_idle_after", 32'(serial_out), 32'h0);
        checkOutput("switch_pin_hold", 32'(pin_status), 32'h81);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, rx_c[7-i]);
            if (i == 6) checkOutput("switch_rx_partial", 32'(pin_status), 32'h81);
        end
        checkOutput("switch_rx_word", 32'(pin_status), 32'h96);
        checkOutput("switch_rx_serial_out", 32'(serial_out), 32'h0);

        // Reset in the middle of operation discards queued words
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        wrst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        wrst_n = 1'b1;
        checkOutput("midreset_pin_status", 32'(pin_status), 32'h00);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("midreset_no_pop_pin", 32'(pin_status), 32'h00);
        checkOutput("midreset_no_pop_serial", 32'(serial_out), 32'h0);
        checkOutput("midreset_wfull", 32'(wfull), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/gpio_fifo_top_serial.md
Name: gpio_fifo_top_serial

Overview:
Single-clock GPIO serial port with a write-side FIFO. In transmit mode (gpio_direction=1), parallel words written into the FIFO are popped and shifted out MSB-first on serial_out. In receive mode (gpio_direction=0), bits on gpio_in are shifted in and the assembled word is presented on pin_status. The block sits between a register/bus writer and one bidirectional GPIO pin.

Parameters:
DSIZE, 8, data word width and serial frame length in bits.
ASIZE, 4, FIFO address width; depth is 2**ASIZE (16) entries.

Ports:
wclk  input  1  sole clock; all state updates on rising edge.
wrst_n  input  1  reset, synchronous, active-low.
winc  input  1  write strobe; pushes wdata when FIFO not full.
wdata  input  DSIZE  write data.
gpio_direction  input  1  1 = transmit, 0 = receive.
gpio_in  input  1  serial receive input, sampled every cycle in receive.
serial_out  output  1  registered serial transmit output.
pin_status  output  DSIZE  last word transmitted or last word received.
wfull  output  1  FIFO full flag (combinational from pointers).

Behaviour:
- One clock (wclk); reset is synchronous and active-low (wrst_n). No other clock/reset ports.
- Reset (wrst_n=0 at rising edge): FIFO pointers 0 (empty), serial_out=0, pin_status=0, TX FSM IDLE, RX shift register and bit counter 0.
- FIFO: 2**ASIZE x DSIZE memory, ASIZE+1-bit read/write pointers; empty when equal, full when MSBs differ and lower bits equal. Push on edge when winc=1 and !wfull; push while full is dropped, no state change. Pop only by TX FSM. Push and pop in the same cycle both take effect.
- TX FSM states IDLE, SHIFT:
  - IDLE: serial_out held 0. If gpio_direction=1 and FIFO not empty: pop head word W; pin_status<=W; serial_out<=W[DSIZE-1]; tx_sr<=W<<1; bit_cnt<=DSIZE-1; go SHIFT.
  - SHIFT, bit_cnt!=0: serial_out<=tx_sr[DSIZE-1]; tx_sr<<=1; bit_cnt--.
  - SHIFT, bit_cnt==0: if gpio_direction=1 and FIFO not empty, pop next word exactly as in IDLE (back-to-back frames, no gap); else serial_out<=0, go IDLE.
  - Each frame holds serial_out for exactly DSIZE cycles. Latency: word written at edge N emits its first bit after edge N+1 (FIFO previously empty, TX idle).
  - Clearing gpio_direction mid-frame does not abort; the current frame completes, then no further pops.
- RX: active only when gpio_direction=0 and TX FSM is IDLE. Each edge: rx_sr<={rx_sr[DSIZE-2:0],gpio_in}; bit_cnt++. On the DSIZE-th bit, pin_status<={rx_sr[DSIZE-2:0],gpio_in} and the counter restarts at 0. While RX is inactive, the RX counter and rx_sr are cleared; partial words are discarded.
- pin_status changes only on TX pop or RX word completion; otherwise it holds.
- Mid-operation reset: same as power-on reset; FIFO contents are discarded (pointers cleared).

Optional Feature:
Macro GPIO_LSB_FIRST_EN. When defined, TX shifts LSB-first (serial_out<=W[0], tx_sr>>=1) and RX shifts in at MSB (rx_sr<={gpio_in,rx_sr[DSIZE-1:1]}), so word order on the wire is bit0..bitDSIZE-1. When undefined, MSB-first as specified above.

Test Plan:
- Reset: hold wrst_n=0 for 3 edges with winc=1 -> serial_out=0, pin_status=0x00, wfull=0; nothing stored after release.
- Single TX: direction=1, write 0xA5 at edge N -> serial_out 1,0,1,0,0,1,0,1 after edges N+1..N+8, then 0; pin_status=0xA5 after edge N+1.
- Back-to-back: direction=1, write 0x3C,0xFF on consecutive cycles -> 16 contiguous bits 00111100 11111111, no idle gap; pin_status 0x3C then 0xFF.
- Full/overflow: direction=0, write 17 words 0x00..0x10 -> wfull=1 after 16th push, 0x10 dropped; set direction=1 -> 0x00..0x0F stream in 128 consecutive cycles, wfull drops after first pop.
- RX: direction=0, TX idle, drive gpio_in 1,1,0,0,1,0,1,0 on 8 edges -> pin_status=0xCA after 8th edge; unchanged until the next 8 bits.
- Direction switch mid-frame: start TX of 0x81, clear direction after 3 bits -> remaining 5 bits still sent, then RX starts counting from 0.
